// File: rtl/spi_sub_param_if.sv
// spi_sub_param_if: parallel word side of the SPI subordinate
// tx handshake in, received words and status pulses out
interface spi_sub_param_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_underrun;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid,
    input  tx_underrun
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid,
    output tx_underrun
  );
endinterface

// File: rtl/spi_sub_param.sv
// spi_sub_param: oversampled SPI subordinate, any CPOL/CPHA
// Word width and bit order set by parameters
module spi_sub_param #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2,
  parameter int MSB_FIRST   = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cs_n,
  input  logic sck,
  input  logic mosi,
  output wire  miso,
  spi_sub_param_if.slave bus
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic POL = (CPOL != 0);
  localparam logic PHA = (CPHA != 0);
  localparam logic MSB = (MSB_FIRST != 0);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state;
  state_t state_nx;

  logic [SYNC_STAGES-1:0] sck_sr;
  logic [SYNC_STAGES-1:0] cs_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic [SYNC_STAGES-1:0] vld_sr;
  logic sck_s, cs_s, mosi_s;
  logic sck_d, cs_d;

  logic rise, fall, lead, trail;
  logic sample_e, shift_e;
  logic cs_fall, cs_rise;
  logic act, load, samp, shft;

  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] tx_nx;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] rx_nx;
  logic [DATA_W-1:0] rx_q;
  logic              rx_v;
  logic [CW-1:0]     cnt;
  logic              loaded;
  logic              out_bit;

  assign sck_s  = sck_sr[SYNC_STAGES-1];
  assign cs_s   = cs_sr[SYNC_STAGES-1];
  assign mosi_s = mosi_sr[SYNC_STAGES-1];

  // Synchronisers plus one-flop delayed copies for edge detect.
  // cs_d stays low until the chain holds real samples, so a
  // cs_n already low at reset release is not seen as a fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sr  <= {SYNC_STAGES{POL}};
      cs_sr   <= {SYNC_STAGES{1'b1}};
      mosi_sr <= '0;
      vld_sr  <= '0;
      sck_d   <= POL;
      cs_d    <= 1'b0;
    end else begin
      sck_sr  <= {sck_sr[SYNC_STAGES-2:0], sck};
      cs_sr   <= {cs_sr[SYNC_STAGES-2:0], cs_n};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
      vld_sr  <= {vld_sr[SYNC_STAGES-2:0], 1'b1};
      sck_d   <= sck_s;
      cs_d    <= vld_sr[SYNC_STAGES-1] & cs_s;
    end
  end

  // Classify sck edges as sample or shift; sample wins a tie.
  always_comb begin
    rise     = sck_s & ~sck_d;
    fall     = ~sck_s & sck_d;
    lead     = POL ? fall : rise;
    trail    = POL ? rise : fall;
    sample_e = PHA ? trail : lead;
    shift_e  = (PHA ? lead : trail) & ~sample_e;
    cs_fall  = cs_d & ~cs_s;
    cs_rise  = ~cs_d & cs_s;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state: follow the synchronised chip select.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (cs_fall) state_nx = ACTIVE;
      ACTIVE:  if (cs_rise) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Per-cycle actions; a word loads once, on its first shift slot.
  always_comb begin
    act  = 1'b0;
    load = 1'b0;
    samp = 1'b0;
    shft = 1'b0;
    unique case (state)
      IDLE: begin
        load = cs_fall & ~PHA;
      end
      ACTIVE: begin
        act  = ~cs_rise;
        samp = act & sample_e;
        load = act & shift_e & ~loaded;
        shft = act & shift_e & loaded;
      end
      default: begin
        act = 1'b0;
      end
    endcase
  end

  assign bus.tx_ready    = load & bus.tx_valid;
  assign bus.tx_underrun = load & ~bus.tx_valid;

  // Shift directions and the outgoing bit.
  always_comb begin
    if (MSB) begin
      tx_nx   = {tx_sr[DATA_W-2:0], 1'b0};
      rx_nx   = {rx_sr[DATA_W-2:0], mosi_s};
      out_bit = tx_sr[DATA_W-1];
    end else begin
      tx_nx   = {1'b0, tx_sr[DATA_W-1:1]};
      rx_nx   = {mosi_s, rx_sr[DATA_W-1:1]};
      out_bit = tx_sr[0];
    end
  end

  // Shift/receive registers, bit counter and word publish.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_sr  <= '0;
      rx_sr  <= '0;
      rx_q   <= '0;
      rx_v   <= 1'b0;
      cnt    <= '0;
      loaded <= 1'b0;
    end else begin
      rx_v <= 1'b0;
      if (state == ACTIVE && cs_rise) begin
        cnt    <= '0;
        loaded <= 1'b0;
        rx_sr  <= '0;
      end
      if (load) begin
        tx_sr  <= bus.tx_valid ? bus.tx_data : '0;
        loaded <= 1'b1;
      end else if (shft) begin
        tx_sr <= tx_nx;
      end
      if (samp) begin
        rx_sr <= rx_nx;
        if (cnt == LAST) begin
          cnt    <= '0;
          loaded <= 1'b0;
          rx_q   <= rx_nx;
          rx_v   <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign bus.rx_data  = rx_q;
  assign bus.rx_valid = rx_v;

  assign miso = cs_n ? 1'bz : out_bit;

endmodule

// File: tb/tb_spi_sub_param.sv
// tb_spi_sub_param: three configurations driven by a bit-level
// SPI master; words checked through a scoreboard queue
`timescale 1ns/1ps
module tb_spi_sub_param;

  localparam int H = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [2:0] cs_n;
  logic [2:0] sck;
  logic [2:0] mosi;
  wire        miso0, miso1, miso2;

  pullup pu0 (miso0);
  pullup pu1 (miso1);
  pullup pu2 (miso2);

  spi_sub_param_if #(.DATA_W(8))  b0 ();
  spi_sub_param_if #(.DATA_W(16)) b1 ();
  spi_sub_param_if #(.DATA_W(8))  b2 ();

  spi_sub_param #(
    .DATA_W(8), .CPOL(0), .CPHA(0),
    .SYNC_STAGES(2), .MSB_FIRST(1)
  ) u0 (
    .clk(clk), .reset_n(reset_n), .cs_n(cs_n[0]),
    .sck(sck[0]), .mosi(mosi[0]), .miso(miso0), .bus(b0)
  );

  spi_sub_param #(
    .DATA_W(16), .CPOL(1), .CPHA(1),
    .SYNC_STAGES(3), .MSB_FIRST(0)
  ) u1 (
    .clk(clk), .reset_n(reset_n), .cs_n(cs_n[1]),
    .sck(sck[1]), .mosi(mosi[1]), .miso(miso1), .bus(b1)
  );

  spi_sub_param #(
    .DATA_W(8), .CPOL(0), .CPHA(1),
    .SYNC_STAGES(4), .MSB_FIRST(1)
  ) u2 (
    .clk(clk), .reset_n(reset_n), .cs_n(cs_n[2]),
    .sck(sck[2]), .mosi(mosi[2]), .miso(miso2), .bus(b2)
  );

  int errors = 0;
  int checks = 0;
  int rdy [3];
  int unr [3];
  logic [31:0] last_rx [3];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] q2 [$];
  logic [31:0] mw [5];
  logic [31:0] tw [5];
  bit          tv [5];

  function automatic int wd(input int k);
    return (k == 1) ? 16 : 8;
  endfunction

  function automatic bit pha(input int k);
    return k != 0;
  endfunction

  function automatic bit msbf(input int k);
    return k != 1;
  endfunction

  function automatic logic [31:0] mask(input int k);
    return (32'h1 << wd(k)) - 32'h1;
  endfunction

  function automatic void chk(input string n,
                              input logic [31:0] a,
                              input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endfunction

  function automatic void push(input int k, input logic [31:0] v);
    case (k)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [31:0] pop(input int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic logic miso_of(input int k);
    case (k)
      0:       return miso0;
      1:       return miso1;
      default: return miso2;
    endcase
  endfunction

  function automatic logic [31:0] rxd_of(input int k);
    case (k)
      0:       return 32'(b0.rx_data);
      1:       return 32'(b1.rx_data);
      default: return 32'(b2.rx_data);
    endcase
  endfunction

  function automatic logic [31:0] pulses_of(input int k);
    case (k)
      0: return 32'({b0.rx_valid, b0.tx_ready, b0.tx_underrun});
      1: return 32'({b1.rx_valid, b1.tx_ready, b1.tx_underrun});
      default:
        return 32'({b2.rx_valid, b2.tx_ready, b2.tx_underrun});
    endcase
  endfunction

  task automatic set_tx(input int k, input bit v,
                        input logic [31:0] d);
    case (k)
      0: begin b0.tx_valid = v; b0.tx_data = d[7:0]; end
      1: begin b1.tx_valid = v; b1.tx_data = d[15:0]; end
      default: begin b2.tx_valid = v; b2.tx_data = d[7:0]; end
    endcase
  endtask

  task automatic fill(input int k);
    for (int i = 0; i < 5; i++) begin
      mw[i] = $urandom & mask(k);
      tw[i] = $urandom & mask(k);
      tv[i] = 1'b1;
    end
  endtask

  // Monitor: every rx_valid pops one expected word.
  task automatic mon(input int k, input logic v,
                     input logic [31:0] d);
    logic [31:0] e;
    if (v) begin
      if (qsize(k) == 0) begin
        checks++;
        errors++;
        $display("FAIL rx%0d_spurious: got %h expected none", k, d);
      end else begin
        e = pop(k);
        chk($sformatf("rx%0d_word", k), d, e);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, b0.rx_valid, 32'(b0.rx_data));
    mon(1, b1.rx_valid, 32'(b1.rx_data));
    mon(2, b2.rx_valid, 32'(b2.rx_data));
    if (b0.tx_ready)    rdy[0]++;
    if (b1.tx_ready)    rdy[1]++;
    if (b2.tx_ready)    rdy[2]++;
    if (b0.tx_underrun) unr[0]++;
    if (b1.tx_underrun) unr[1]++;
    if (b2.tx_underrun) unr[2]++;
  end

  // Master: nw full words then `part` bits, then cs_n high.
  // Word w transmits tw[w] if tv[w], else zeros.
  task automatic xfer(input int k, input int nw, input int part);
    int  wid, r0, u0, rexp, uexp, nb, idx;
    bit  ld, m;
    wid  = wd(k);
    r0   = rdy[k];
    u0   = unr[k];
    rexp = 0;
    uexp = 0;
    for (int w = 0; w <= nw; w++) begin
      ld = (w < nw) || !pha(k) || (part > 0);
      if (ld && tv[w]) rexp++;
      else if (ld) uexp++;
    end
    set_tx(k, tv[0], tw[0]);
    @(negedge clk);
    cs_n[k] = 1'b0;
    for (int w = 0; w <= nw; w++) begin
      nb = (w == nw) ? part : wid;
      for (int b = 0; b < nb; b++) begin
        idx = msbf(k) ? wid - 1 - b : b;
        repeat (H / 2) @(negedge clk);
        mosi[k] = mw[w][idx];
        for (int e = 0; e < 2; e++) begin
          repeat (H) @(negedge clk);
          if ((e == 1) == pha(k)) begin
            m = tv[w] ? tw[w][idx] : 1'b0;
            chk($sformatf("miso%0d_w%0d_b%0d", k, w, b),
                32'(miso_of(k)), 32'(m));
            sck[k] = ~sck[k];
            if (b == wid - 1) begin
              push(k, mw[w]);
              last_rx[k] = mw[w];
              set_tx(k, tv[w+1], tw[w+1]);
            end
          end else begin
            sck[k] = ~sck[k];
          end
        end
      end
    end
    repeat (H) @(negedge clk);
    cs_n[k] = 1'b1;
    mosi[k] = 1'b0;
    repeat (3 * H) @(negedge clk);
    chk($sformatf("tx_ready%0d_count", k), 32'(rdy[k] - r0),
        32'(rexp));
    chk($sformatf("underrun%0d_count", k), 32'(unr[k] - u0),
        32'(uexp));
    chk($sformatf("rx%0d_missing", k), 32'(qsize(k)), 32'd0);
    chk($sformatf("rx%0d_hold", k), rxd_of(k), last_rx[k]);
    chk($sformatf("miso%0d_hiz", k), 32'(miso_of(k)), 32'd1);
    set_tx(k, 1'b0, 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, u0, k, nw, part;
    reset_n = 1'b0;
    cs_n    = 3'b111;
    sck     = 3'b010;
    mosi    = 3'b000;
    for (int i = 0; i < 3; i++) begin
      set_tx(i, 1'b0, 32'd0);
      last_rx[i] = '0;
      rdy[i] = 0;
      unr[i] = 0;
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_pulses%0d", i), pulses_of(i), 32'd0);
      chk($sformatf("reset_rx%0d", i), rxd_of(i), 32'd0);
      chk($sformatf("reset_miso%0d", i), 32'(miso_of(i)), 32'd1);
    end
    reset_n = 1'b1;
    repeat (8) @(negedge clk);

    // Mode 0: A5 out, 3C in; no word queued for the next slot.
    fill(0);
    mw[0] = 32'h3C;
    tw[0] = 32'hA5;
    tv[1] = 1'b0;
    xfer(0, 1, 0);

    // Mode 3, 16-bit LSB first, three-word burst.
    fill(1);
    mw[0] = 32'h1234;
    mw[1] = 32'hBEEF;
    mw[2] = 32'h0001;
    xfer(1, 3, 0);

    // Mode 1 with nothing to send.
    fill(2);
    tv[0] = 1'b0;
    xfer(2, 1, 0);

    // Abort after 5 bits, then a clean 0x81.
    fill(0);
    xfer(0, 0, 5);
    fill(0);
    mw[0] = 32'h81;
    xfer(0, 1, 0);

    // Reset in the middle of a word.
    fill(0);
    set_tx(0, 1'b1, tw[0]);
    @(negedge clk);
    cs_n[0] = 1'b0;
    repeat (3) begin
      repeat (H / 2) @(negedge clk);
      mosi[0] = 1'($urandom);
      repeat (H) @(negedge clk);
      sck[0] = 1'b1;
      repeat (H) @(negedge clk);
      sck[0] = 1'b0;
    end
    repeat (H) @(negedge clk);
    r0 = rdy[0];
    u0 = unr[0];
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset_pulses", pulses_of(0), 32'd0);
    chk("midreset_rx", rxd_of(0), 32'd0);
    chk("midreset_miso", 32'(miso_of(0)), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) last_rx[i] = '0;
    repeat (2 * H) @(negedge clk);
    cs_n[0] = 1'b1;
    mosi[0] = 1'b0;
    set_tx(0, 1'b0, 32'd0);
    repeat (2 * H) @(negedge clk);
    chk("midreset_ready", 32'(rdy[0] - r0), 32'd0);
    chk("midreset_underrun", 32'(unr[0] - u0), 32'd0);
    chk("midreset_hiz", 32'(miso_of(0)), 32'd1);
    fill(0);
    xfer(0, 1, 0);

    // sck activity with cs_n high must be ignored.
    r0 = rdy[0];
    u0 = unr[0];
    repeat (20) begin
      repeat (H / 2) @(negedge clk);
      mosi[0] = 1'($urandom);
      repeat (H / 2) @(negedge clk);
      sck[0] = ~sck[0];
    end
    repeat (2 * H) @(negedge clk);
    chk("idle_ready", 32'(rdy[0] - r0), 32'd0);
    chk("idle_underrun", 32'(unr[0] - u0), 32'd0);
    chk("idle_miso", 32'(miso_of(0)), 32'd1);
    mosi[0] = 1'b0;
    fill(0);
    xfer(0, 2, 0);

    // Random transfers across all three configurations.
    for (int t = 0; t < 24; t++) begin
      k    = $urandom_range(0, 2);
      nw   = $urandom_range(0, 3);
      part = $urandom_range(0, wd(k) - 1);
      if (nw == 0 && part == 0) nw = 1;
      fill(k);
      for (int i = 0; i < 5; i++) tv[i] = ($urandom_range(0, 3) != 0);
      xfer(k, nw, part);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
